ascon_decrypt_core: RTL and testbench
=====================================

Name: ascon_decrypt_core

Overview:
- ASCON-128 decryption engine; the receive-side counterpart of the encryption permutation datapath.
- Starts from an initialised, AD-absorbed 320-bit state and decrypts a stream of full 64-bit ciphertext blocks through a valid/ready handshake.
- Runs finalization and compares the computed tag against the received tag.
- Contains its own single-round-per-cycle permutation: constant addition, bitsliced 5-bit S-box and linear diffusion layer, as defined in ascon_pack.

Parameters:
- ROUNDS_B, 6, rounds of pb between ciphertext blocks (rounds 12-ROUNDS_B..11).
- ROUNDS_A, 12, rounds of pa for finalization (rounds 0..11).

Ports:
- clock_i  in  1  system clock; all state updates on the rising edge.
- resetb_i  in  1  asynchronous active-low reset.
- load_i  in  1  load state_i; honoured only in IDLE.
- state_i  in  320 (type_state)  initial state; S0 = state_i[0].
- key_i  in  128  key; K_hi = key_i[127:64], K_lo = key_i[63:0].
- tag_i  in  128  received tag; tag_i[127:64] compares with S3, tag_i[63:0] with S4.
- cipher_i  in  64  ciphertext block.
- cipher_valid_i  in  1  cipher_i valid.
- cipher_last_i  in  1  marks the final block; qualified by valid.
- cipher_ready_o  out  1  block can be accepted this cycle.
- plain_o  out  64  plaintext block.
- plain_valid_o  out  1  one-cycle pulse; plain_o valid.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at end of finalization.
- tag_ok_o  out  1  tag match result; valid from done_o until the next load.

Behaviour:
- Reset (asynchronous, resetb_i=0):
  - FSM goes to IDLE; state registers, round counter, plain_o, tag_ok_o go to 0.
  - cipher_ready_o, plain_valid_o, done_o, busy_o go to 0.
  - Reset mid-operation aborts the operation; no done_o is produced.
- FSM states: IDLE, WAIT_CT, PB, PA, TAG.
- IDLE:
  - load_i=1 latches state_i and goes to WAIT_CT on the next edge.
  - tag_ok_o is cleared on load.
- WAIT_CT:
  - cipher_ready_o=1 (combinational from state); it is 0 in all other states.
  - Accept occurs on an edge with cipher_valid_i=1 while cipher_ready_o=1.
  - On accept: plain_o <= S0 ^ cipher_i; plain_valid_o=1 for the following cycle only; S0 <= cipher_i.
  - Not last: round counter <= 12-ROUNDS_B, go to PB.
  - Last: in the same edge S1 ^= K_hi and S2 ^= K_lo; round counter <= 0; go to PA.
- PB:
  - One round per cycle.
  - Round r constant c_r = {4'hF-r, r[3:0]}, XORed into S2[7:0] before the S-box.
  - After the edge that executes round 11, return to WAIT_CT.
  - Exactly ROUNDS_B cycles; ready is low throughout, and valid during PB is ignored (not consumed).
- PA:
  - Rounds 0..11, one per cycle.
  - On the edge executing round 11, also apply S3 ^= K_hi and S4 ^= K_lo after the round; then go to TAG.
- TAG (one cycle):
  - tag_ok_o <= ({S3,S4} == tag_i).
  - done_o=1 for that cycle; next state IDLE.
- Latency:
  - Accept of a non-last block to the next cycle with ready=1: ROUNDS_B+1 cycles.
  - Accept of the last block to the done_o cycle: 13 cycles (12 PA + 1 TAG).
- load_i while busy_o=1 is ignored.
- cipher_i and cipher_last_i are ignored unless accepted.
- Only full 64-bit blocks are supported; partial-block padding is out of scope.
- All width arithmetic is 64-bit lane-wise, and rotations are right-rotations per the ASCON linear layer:
  - S0: 19, 28
  - S1: 61, 39
  - S2: 1, 6
  - S3: 10, 17
  - S4: 7, 41

Test Plan:
1. Reset then load state {4608da0e76fcee25, 876f2d998dd3ed21, 5d5b8b59b7ac16ee, e23c656f97f63dc8, 3e09499302483746}; send cipher_i=436F6E636576657A (not last) -> plain_o=0567B46D138A8B5F with one plain_valid_o pulse; ready low for 6 cycles, then high again.
2. Round trip: golden encryption model produces ciphertext for plaintext blocks 436F6E636576657A, 204153434F4E2065, 6E2053797374656D with key 000102030405060708090A0B0C0D0E0F; feed them with last on the third block -> the three plaintexts are recovered in order; done_o arrives 13 cycles after the last accept; tag_ok_o=1 with the model tag.
3. Same stream with tag_i bit 0 flipped -> identical plaintexts; tag_ok_o=0 at done_o.
4. Hold cipher_valid_i=1 continuously, including during PB -> exactly one accept per WAIT_CT visit; no block is lost or duplicated.
5. Pulse resetb_i low during PA round 5 -> all outputs 0 immediately; no done_o; after a new load the engine decrypts correctly.
6. Assert load_i during PB with a different state_i -> ignored; results match scenario 2.

Source files
------------

// File: rtl/ascon_decrypt_core.sv
// ASCON-128 decryption engine. It takes a preloaded 320-bit state, absorbs full
// 64-bit ciphertext blocks, then finalizes and compares the computed tag.
module ascon_decrypt_core #(
  parameter int ROUNDS_B = 6,
  parameter int ROUNDS_A = 12
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         load_i,
  input  logic [319:0] state_i,
  input  logic [127:0] key_i,
  input  logic [127:0] tag_i,
  input  logic [63:0]  cipher_i,
  input  logic         cipher_valid_i,
  input  logic         cipher_last_i,
  output logic         cipher_ready_o,
  output logic [63:0]  plain_o,
  output logic         plain_valid_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         tag_ok_o
);

  // state   | meaning
  // IDLE    | waiting for load_i
  // WAIT_CT | ready to accept the next ciphertext block
  // PB      | intermediate rounds between blocks
  // PA      | finalization rounds, keyed at both ends
  // TAG     | done_o pulse, tag_ok_o holds the comparison
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAIT_CT = 3'd1;
  localparam logic [2:0] PB      = 3'd2;
  localparam logic [2:0] PA      = 3'd3;
  localparam logic [2:0] TAG     = 3'd4;

  localparam logic [3:0] PB_START = 4'(12 - ROUNDS_B);
  localparam logic [3:0] PA_START = 4'(12 - ROUNDS_A);
  localparam logic [3:0] LAST_RND = 4'd11;

  logic [2:0]  r_state;
  logic [3:0]  r_round;
  logic [63:0] r_x0, r_x1, r_x2, r_x3, r_x4;
  logic [63:0] r_plain;
  logic        r_plain_valid;
  logic        r_tag_ok;

  logic [63:0] w_k_hi, w_k_lo;
  logic [63:0] w_c2;
  logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;
  logic [63:0] w_u0, w_u1, w_u2, w_u3, w_u4;
  logic [63:0] w_v0, w_v1, w_v2, w_v3, w_v4;
  logic [63:0] w_l0, w_l1, w_l2, w_l3, w_l4;
  logic [63:0] w_f3, w_f4;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  assign w_k_hi = key_i[127:64];
  assign w_k_lo = key_i[63:0];

  // round constant: high nibble counts down from F while the low nibble counts up
  assign w_c2 = r_x2 ^ {56'd0, 4'hF - r_round, r_round};

  assign w_t0 = r_x0 ^ r_x4;
  assign w_t1 = r_x1;
  assign w_t2 = w_c2 ^ r_x1;
  assign w_t3 = r_x3;
  assign w_t4 = r_x4 ^ r_x3;

  assign w_u0 = w_t0 ^ (~w_t1 & w_t2);
  assign w_u1 = w_t1 ^ (~w_t2 & w_t3);
  assign w_u2 = w_t2 ^ (~w_t3 & w_t4);
  assign w_u3 = w_t3 ^ (~w_t4 & w_t0);
  assign w_u4 = w_t4 ^ (~w_t0 & w_t1);

  assign w_v0 = w_u0 ^ w_u4;
  assign w_v1 = w_u1 ^ w_u0;
  assign w_v2 = ~w_u2;
  assign w_v3 = w_u3 ^ w_u2;
  assign w_v4 = w_u4;

  assign w_l0 = w_v0 ^ rotr(w_v0, 19) ^ rotr(w_v0, 28);
  assign w_l1 = w_v1 ^ rotr(w_v1, 61) ^ rotr(w_v1, 39);
  assign w_l2 = w_v2 ^ rotr(w_v2, 1)  ^ rotr(w_v2, 6);
  assign w_l3 = w_v3 ^ rotr(w_v3, 10) ^ rotr(w_v3, 17);
  assign w_l4 = w_v4 ^ rotr(w_v4, 7)  ^ rotr(w_v4, 41);

  assign w_f3 = w_l3 ^ w_k_hi;
  assign w_f4 = w_l4 ^ w_k_lo;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state       <= IDLE;
      r_round       <= 4'd0;
      r_x0          <= 64'd0;
      r_x1          <= 64'd0;
      r_x2          <= 64'd0;
      r_x3          <= 64'd0;
      r_x4          <= 64'd0;
      r_plain       <= 64'd0;
      r_plain_valid <= 1'b0;
      r_tag_ok      <= 1'b0;
    end else begin
      r_plain_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_i) begin
            r_x0     <= state_i[63:0];
            r_x1     <= state_i[127:64];
            r_x2     <= state_i[191:128];
            r_x3     <= state_i[255:192];
            r_x4     <= state_i[319:256];
            r_tag_ok <= 1'b0;
            r_state  <= WAIT_CT;
          end
        end
        WAIT_CT: begin
          if (cipher_valid_i) begin
            r_plain       <= r_x0 ^ cipher_i;
            r_plain_valid <= 1'b1;
            r_x0          <= cipher_i;
            if (cipher_last_i) begin
              r_x1    <= r_x1 ^ w_k_hi;
              r_x2    <= r_x2 ^ w_k_lo;
              r_round <= PA_START;
              r_state <= PA;
            end else begin
              r_round <= PB_START;
              r_state <= PB;
            end
          end
        end
        PB: begin
          r_x0    <= w_l0;
          r_x1    <= w_l1;
          r_x2    <= w_l2;
          r_x3    <= w_l3;
          r_x4    <= w_l4;
          r_round <= r_round + 4'd1;
          if (r_round == LAST_RND) r_state <= WAIT_CT;
        end
        PA: begin
          r_x0    <= w_l0;
          r_x1    <= w_l1;
          r_x2    <= w_l2;
          r_round <= r_round + 4'd1;
          if (r_round == LAST_RND) begin
            // tag compare uses the keyed lanes so tag_ok_o is already valid when done_o rises
            r_x3     <= w_f3;
            r_x4     <= w_f4;
            r_tag_ok <= ({w_f3, w_f4} == tag_i);
            r_state  <= TAG;
          end else begin
            r_x3 <= w_l3;
            r_x4 <= w_l4;
          end
        end
        TAG: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cipher_ready_o = (r_state == WAIT_CT);
  assign busy_o         = (r_state != IDLE);
  assign done_o         = (r_state == TAG);
  assign plain_o        = r_plain;
  assign plain_valid_o  = r_plain_valid;
  assign tag_ok_o       = r_tag_ok;

endmodule

// File: tb/tb_ascon_decrypt_core.sv
// Bench for ascon_decrypt_core: an encryption model built on a table S-box
// generates ciphertext and tags; a monitor checks plaintext, tag and timing.
module tb_ascon_decrypt_core;
  localparam int ROUNDS_B = 6;

  logic         clock_i = 1'b0;
  logic         resetb_i;
  logic         load_i;
  logic [319:0] state_i;
  logic [127:0] key_i;
  logic [127:0] tag_i;
  logic [63:0]  cipher_i;
  logic         cipher_valid_i;
  logic         cipher_last_i;
  logic         cipher_ready_o;
  logic [63:0]  plain_o;
  logic         plain_valid_o;
  logic         busy_o;
  logic         done_o;
  logic         tag_ok_o;

  ascon_decrypt_core #(.ROUNDS_B(ROUNDS_B), .ROUNDS_A(12)) dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .load_i(load_i), .state_i(state_i),
    .key_i(key_i), .tag_i(tag_i), .cipher_i(cipher_i), .cipher_valid_i(cipher_valid_i),
    .cipher_last_i(cipher_last_i), .cipher_ready_o(cipher_ready_o), .plain_o(plain_o),
    .plain_valid_o(plain_valid_o), .busy_o(busy_o), .done_o(done_o), .tag_ok_o(tag_ok_o)
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 0;

  always @(posedge clock_i) cyc <= cyc + 1;

  logic [63:0]  exp_pt_q[$];
  int           exp_pv_cyc_q[$];
  bit           exp_ok_q[$];
  int           exp_done_cyc_q[$];

  logic [63:0]  pt_blk[8];
  logic [63:0]  ct_blk[8];
  logic [319:0] init_st;
  logic [127:0] key_r;
  logic [127:0] model_tag;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [4:0] sbox(input logic [4:0] x);
    case (x)
      5'd0:  return 5'h04;  5'd1:  return 5'h0b;  5'd2:  return 5'h1f;  5'd3:  return 5'h14;
      5'd4:  return 5'h1a;  5'd5:  return 5'h15;  5'd6:  return 5'h09;  5'd7:  return 5'h02;
      5'd8:  return 5'h1b;  5'd9:  return 5'h05;  5'd10: return 5'h08;  5'd11: return 5'h12;
      5'd12: return 5'h1d;  5'd13: return 5'h03;  5'd14: return 5'h06;  5'd15: return 5'h1c;
      5'd16: return 5'h1e;  5'd17: return 5'h13;  5'd18: return 5'h07;  5'd19: return 5'h0e;
      5'd20: return 5'h00;  5'd21: return 5'h0d;  5'd22: return 5'h11;  5'd23: return 5'h18;
      5'd24: return 5'h10;  5'd25: return 5'h0c;  5'd26: return 5'h01;  5'd27: return 5'h19;
      5'd28: return 5'h16;  5'd29: return 5'h0a;  5'd30: return 5'h0f;  default: return 5'h17;
    endcase
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] st, input int first);
    logic [63:0] x[5];
    logic [63:0] y[5];
    logic [4:0]  v, o;
    logic [319:0] res;
    for (int k = 0; k < 5; k++) x[k] = st[64*k +: 64];
    for (int r = first; r < 12; r++) begin
      x[2][7:0] = x[2][7:0] ^ 8'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = sbox(v);
        y[0][b] = o[4]; y[1][b] = o[3]; y[2][b] = o[2]; y[3][b] = o[1]; y[4][b] = o[0];
      end
      x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
      x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
      x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
      x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
      x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
    end
    for (int k = 0; k < 5; k++) res[64*k +: 64] = x[k];
    return res;
  endfunction

  task automatic model_encrypt(input int n);
    logic [319:0] s;
    s = init_st;
    for (int i = 0; i < n; i++) begin
      ct_blk[i] = s[63:0] ^ pt_blk[i];
      s[63:0]   = ct_blk[i];
      if (i < n - 1) begin
        s = perm(s, 12 - ROUNDS_B);
      end else begin
        s[127:64]  = s[127:64]  ^ key_r[127:64];
        s[191:128] = s[191:128] ^ key_r[63:0];
        s = perm(s, 0);
        s[255:192] = s[255:192] ^ key_r[127:64];
        s[319:256] = s[319:256] ^ key_r[63:0];
      end
    end
    model_tag = {s[255:192], s[319:256]};
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock_i) begin
    if (mon_en) begin
      if (plain_valid_o === 1'b1) begin
        if (exp_pt_q.size() == 0) check("plain_valid_o spurious", plain_valid_o, 1'b0);
        else begin
          check("plain_o", plain_o, exp_pt_q.pop_front());
          check("plain_valid timing", cyc, exp_pv_cyc_q.pop_front());
        end
      end
      if (done_o === 1'b1) begin
        if (exp_ok_q.size() == 0) check("done_o spurious", done_o, 1'b0);
        else begin
          check("tag_ok_o at done", tag_ok_o, exp_ok_q.pop_front());
          check("done timing", cyc, exp_done_cyc_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_reset();
    resetb_i = 1'b0;
    load_i = 1'b0; cipher_valid_i = 1'b0; cipher_last_i = 1'b0;
    exp_pt_q.delete(); exp_pv_cyc_q.delete(); exp_ok_q.delete(); exp_done_cyc_q.delete();
    repeat (3) @(negedge clock_i);
    check("reset outputs", {plain_o, plain_valid_o, cipher_ready_o, busy_o, done_o, tag_ok_o}, '0);
    resetb_i = 1'b1;
    @(negedge clock_i);
  endtask

  task automatic load_engine();
    @(posedge clock_i); #1;
    load_i = 1'b1; state_i = init_st; key_i = key_r;
    @(posedge clock_i); #1;
    load_i = 1'b0;
    @(negedge clock_i);
    check("after load busy/ready/tag_ok", {busy_o, cipher_ready_o, tag_ok_o}, 3'b110);
  endtask

  // end_last=0 leaves the final block unmarked; abort pulses reset in PA round 5
  task automatic run_stream(input int n, input bit end_last, input bit hold,
                            input logic [127:0] tag_flip, input bit glitch_load, input bit abort);
    int acc;
    int w;
    bit last;
    tag_i = model_tag ^ tag_flip;
    load_engine();
    for (int i = 0; i < n; i++) begin
      last = end_last && (i == n - 1);
      cipher_i = ct_blk[i]; cipher_last_i = last; cipher_valid_i = 1'b1;
      w = 0;
      while (!cipher_ready_o && w < 40) begin @(negedge clock_i); w++; end
      if (!cipher_ready_o) begin
        check("ready wait timeout", cipher_ready_o, 1'b1);
        cipher_valid_i = 1'b0;
        return;
      end
      acc = cyc;
      exp_pt_q.push_back(pt_blk[i]);
      exp_pv_cyc_q.push_back(acc + 1);
      if (last && !abort) begin
        exp_ok_q.push_back(tag_flip == '0);
        exp_done_cyc_q.push_back(acc + 13);
      end
      @(posedge clock_i); #1;
      if (hold && i < n - 1) begin
        cipher_i = ct_blk[i+1]; cipher_last_i = end_last && (i + 1 == n - 1);
      end else begin
        cipher_valid_i = 1'b0;
      end
      if (!last) begin
        for (int k = 1; k <= ROUNDS_B + 1; k++) begin
          if (glitch_load && k == 2) begin
            load_i = 1'b1;
            state_i = {$urandom, $urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom, $urandom};
          end
          @(negedge clock_i);
          check("ready gap", {cipher_ready_o, busy_o}, {(k == ROUNDS_B + 1), 1'b1});
        end
        load_i = 1'b0;
      end else if (abort) begin
        repeat (5) @(posedge clock_i);
        #2;
        resetb_i = 1'b0;
        #1;
        check("abort outputs", {plain_o, plain_valid_o, cipher_ready_o, busy_o, done_o, tag_ok_o}, '0);
        exp_ok_q.delete(); exp_done_cyc_q.delete();
        repeat (3) @(negedge clock_i);
        resetb_i = 1'b1;
        repeat (20) @(negedge clock_i);
        check("idle after abort", busy_o, 1'b0);
      end else begin
        repeat (15) @(negedge clock_i);
        check("done seen", exp_done_cyc_q.size(), 0);
        check("idle after done", busy_o, 1'b0);
        check("tag_ok_o held", tag_ok_o, tag_flip == '0);
      end
    end
  endtask

  task automatic set_vector2();
    init_st = {64'h3e09499302483746, 64'he23c656f97f63dc8, 64'h5d5b8b59b7ac16ee,
               64'h876f2d998dd3ed21, 64'h4608da0e76fcee25};
    key_r = 128'h000102030405060708090A0B0C0D0E0F;
    pt_blk[0] = 64'h436F6E636576657A;
    pt_blk[1] = 64'h204153434F4E2065;
    pt_blk[2] = 64'h6E2053797374656D;
    model_encrypt(3);
  endtask

  initial begin
    logic [127:0] one;
    int n;
    one = 128'd1;
    resetb_i = 1'b0; load_i = 1'b0; state_i = '0; key_i = '0; tag_i = '0;
    cipher_i = '0; cipher_valid_i = 1'b0; cipher_last_i = 1'b0;
    mon_en = 1'b1;
    do_reset();

    // 1: single non-last block with literal expectations
    init_st = {64'h3e09499302483746, 64'he23c656f97f63dc8, 64'h5d5b8b59b7ac16ee,
               64'h876f2d998dd3ed21, 64'h4608da0e76fcee25};
    key_r = 128'h000102030405060708090A0B0C0D0E0F;
    ct_blk[0] = 64'h436F6E636576657A;
    pt_blk[0] = 64'h0567B46D138A8B5F;
    model_tag = '0;
    run_stream(1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("ct0 model vs literal", ct_blk[0] ^ init_st[63:0], pt_blk[0]);
    do_reset();

    // 2: round trip with good tag
    set_vector2();
    check("model ct0", ct_blk[0], 64'h0567B46D138A8B5F ^ 64'h4608da0e76fcee25 ^ 64'h436F6E636576657A ^ 64'h0567B46D138A8B5F);
    run_stream(3, 1'b1, 1'b0, '0, 1'b0, 1'b0);

    // 3: corrupted tag bit 0
    run_stream(3, 1'b1, 1'b0, one, 1'b0, 1'b0);

    // 4: valid held high through PB
    run_stream(3, 1'b1, 1'b1, '0, 1'b0, 1'b0);

    // 5: reset during PA round 5, then a clean decrypt
    run_stream(3, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    run_stream(3, 1'b1, 1'b0, '0, 1'b0, 1'b0);

    // 6: load during PB is ignored
    run_stream(3, 1'b1, 1'b0, '0, 1'b1, 1'b0);

    // randomized streams
    for (int it = 0; it < 4; it++) begin
      init_st = {$urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom, $urandom};
      key_r = {$urandom, $urandom, $urandom, $urandom};
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) pt_blk[i] = {$urandom, $urandom};
      model_encrypt(n);
      run_stream(n, 1'b1, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? (one << $urandom_range(0, 127)) : '0,
                 1'b0, 1'b0);
    end

    check("leftover plaintext", exp_pt_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
